// File: rtl/and_result_pkg.sv
// Shared types and elaboration helpers for the AND-result buffer.
package and_result_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    typedef logic [DATA_W_DEF-1:0] result_t;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/and_result_buffer_mem.sv
// Storage array for the result FIFO: one write port, one asynchronous read port.
module and_result_buffer_mem
    import and_result_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents survive reset; only the pointers in the parent decide validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/and_result_buffer.sv
// Show-ahead FIFO buffering clocked AND results behind a valid/ready interface.
// Optional feature macro: RESULT_PARITY_EN adds out_parity (^out_data, 0 while empty).
module and_result_buffer
    import and_result_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       clr_ovf
`ifdef RESULT_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
        $fatal(1, "and_result_buffer: DEPTH must be a power of two and >= 2");
    end

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     level_q;
    logic              overflow_q;
    logic [DATA_W-1:0] rdata;
    logic              push;
    logic              pop;
    logic              drop;
    logic              empty_c;
    logic              full_c;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop  = !empty_c && out_ready;
    assign push = in_valid && (!full_c || pop);
    assign drop = in_valid && full_c && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level_q <= level_q + PW'(1);
            end else if (pop && !push) begin
                level_q <= level_q - PW'(1);
            end
            // A drop in the same cycle as clr_ovf keeps the flag set.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_ovf) begin
                overflow_q <= 1'b0;
            end
        end
    end

    and_result_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (push && !reset),
        .waddr  (wr_ptr[AW-1:0]),
        .wdata  (in_data),
        .raddr  (rd_ptr[AW-1:0]),
        .rdata  (rdata)
    );

    assign out_valid = !empty_c;
    assign out_data  = empty_c ? '0 : rdata;
    assign level     = level_q;
    assign full      = full_c;
    assign empty     = empty_c;
    assign overflow  = overflow_q;

`ifdef RESULT_PARITY_EN
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_and_result_buffer.sv
// Directed, table-driven bench for and_result_buffer (DATA_W=8, DEPTH=4).
module tb_and_result_buffer;
    import and_result_pkg::*;

    logic       clk;
    logic       reset;
    logic       in_valid;
    result_t    in_data;
    logic       out_ready;
    logic       out_valid;
    result_t    out_data;
    logic [2:0] level;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       clr_ovf;
`ifdef RESULT_PARITY_EN
    logic       out_parity;
`endif

    int checks = 0;
    int errors = 0;

    and_result_buffer #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf)
`ifdef RESULT_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] din;
        logic       rdy;
        logic       clr;
        logic [2:0] lvl;
        logic       ov;
        logic [7:0] dout;
        logic       fl;
        logic       em;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic iv, logic [7:0] din, logic rdy, logic clr,
                                logic [2:0] lvl, logic ov, logic [7:0] dout,
                                logic fl, logic em, logic ovf);
        vec_t v;
        v.rst = rst; v.iv = iv; v.din = din; v.rdy = rdy; v.clr = clr;
        v.lvl = lvl; v.ov = ov; v.dout = dout; v.fl = fl; v.em = em; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input logic rst, input logic iv, input logic [7:0] din,
                        input logic rdy, input logic clr);
        reset = rst; in_valid = iv; in_data = din; out_ready = rdy; clr_ovf = clr;
        @(posedge clk);
        #1;
    endtask

    result_t model[$];

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; clr_ovf = 1'b0;

        //                rst iv  din    rdy clr  lvl ov dout   fl em ovf
        // reset held with in_valid asserted
        vecs.push_back(mk(1, 1, 8'h11, 0, 0,  0, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(1, 1, 8'h22, 0, 0,  0, 0, 8'h00, 0, 1, 0));
        // two pushes, then drain, then ready while empty
        vecs.push_back(mk(0, 1, 8'hA5, 0, 0,  1, 1, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h3C, 0, 0,  2, 1, 8'hA5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  1, 1, 8'h3C, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0));
        // fill, drop 0x05, drain, sticky overflow, clear
        vecs.push_back(mk(0, 1, 8'h01, 0, 0,  1, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h02, 0, 0,  2, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h03, 0, 0,  3, 1, 8'h01, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h04, 0, 0,  4, 1, 8'h01, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h05, 0, 0,  4, 1, 8'h01, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  3, 1, 8'h02, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  2, 1, 8'h03, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  1, 1, 8'h04, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0,  0, 0, 8'h00, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  0, 0, 8'h00, 0, 1, 0));
        // full with simultaneous push+pop, then drop with clr_ovf (set wins)
        vecs.push_back(mk(0, 1, 8'h41, 0, 0,  1, 1, 8'h41, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h42, 0, 0,  2, 1, 8'h41, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h43, 0, 0,  3, 1, 8'h41, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h44, 0, 0,  4, 1, 8'h41, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h77, 1, 0,  4, 1, 8'h42, 1, 0, 0));
        vecs.push_back(mk(0, 1, 8'h88, 0, 1,  4, 1, 8'h42, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 1,  4, 1, 8'h42, 1, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  3, 1, 8'h43, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  2, 1, 8'h44, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  1, 1, 8'h77, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  0, 0, 8'h00, 0, 1, 0));
        // reset with 3 stored words, push and pop requested in that cycle
        vecs.push_back(mk(0, 1, 8'hFF, 0, 0,  1, 1, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h20, 0, 0,  2, 1, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h21, 0, 0,  3, 1, 8'hFF, 0, 0, 0));
        vecs.push_back(mk(1, 1, 8'h99, 1, 0,  0, 0, 8'h00, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h10, 0, 0,  1, 1, 8'h10, 0, 0, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0,  2, 1, 8'h10, 0, 0, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0,  1, 1, 8'h11, 0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].iv, vecs[i].din, vecs[i].rdy, vecs[i].clr);
            chk($sformatf("v%0d level", i),     32'(level),     32'(vecs[i].lvl));
            chk($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ov));
            chk($sformatf("v%0d out_data", i),  32'(out_data),  32'(vecs[i].dout));
            chk($sformatf("v%0d full", i),      32'(full),      32'(vecs[i].fl));
            chk($sformatf("v%0d empty", i),     32'(empty),     32'(vecs[i].em));
            chk($sformatf("v%0d overflow", i),  32'(overflow),  32'(vecs[i].ovf));
        end

        // Long mixed stream: pointers wrap several times; checked against a queue model.
        model.push_back(8'h11);
        for (int i = 0; i < 30; i++) begin
            logic iv, rdy, mpop, mpush;
            result_t d;
            iv  = (i % 3) != 2;
            rdy = (i % 4) != 0;
            d   = result_t'(8'h60 + i);
            mpop  = (model.size() > 0) && rdy;
            mpush = iv && ((model.size() < 4) || mpop);
            step(1'b0, iv, d, rdy, 1'b0);
            if (mpop) void'(model.pop_front());
            if (mpush) model.push_back(d);
            chk($sformatf("w%0d level", i), 32'(level), 32'(model.size()));
            chk($sformatf("w%0d out_data", i), 32'(out_data),
                model.size() > 0 ? 32'(model[0]) : 32'h0);
            chk($sformatf("w%0d full", i), 32'(full), 32'(model.size() == 4));
        end
        for (int i = 0; i < 6; i++) begin
            logic mpop;
            mpop = model.size() > 0;
            step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            if (mpop) void'(model.pop_front());
            chk($sformatf("d%0d out_data", i), 32'(out_data),
                model.size() > 0 ? 32'(model[0]) : 32'h0);
        end
        chk("drain empty", 32'(empty), 32'h1);

`ifdef RESULT_PARITY_EN
        step(1'b0, 1'b1, 8'h07, 1'b0, 1'b0);
        chk("parity 07", 32'(out_parity), 32'h1);
        step(1'b0, 1'b1, 8'h03, 1'b0, 1'b0);
        chk("parity head 07", 32'(out_parity), 32'h1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("parity 03", 32'(out_parity), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("parity empty", 32'(out_parity), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
